// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Definitions shared by the data-memory responder and its RAM:
//   - FSM state encodings (IDLE / WAIT / RESP)
//   - the write-strobe value that marks a read
//   - the default base address of the data-memory window in the SoC map
//   - a helper that returns the window size in bytes for a word-address width
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0001_0000;

    // Window size in bytes: 2**addr_width words of 4 bytes each.
    function automatic logic [31:0] window_bytes(input int unsigned addr_width);
        return 32'd4 << addr_width;
    endfunction

endpackage

// File: rtl/dmem_ram_bytewe.sv
// -----------------------------------------------------------------------------
// dmem_ram_bytewe
// Single-port synchronous RAM, 32-bit words, four byte-lane write enables.
// Read-before-write: on an enabled edge rdata_o returns the word as it was
// before any lanes written on that same edge.
// Ports:
//   clk      in   clock, rising edge
//   en_i     in   access enable (read always, write per we_i)
//   we_i     in   byte-lane write enables, bit i -> bits [8i+7:8i]
//   addr_i   in   word address
//   wdata_i  in   write data
//   rdata_o  out  registered read data, holds until the next enabled access
// -----------------------------------------------------------------------------
module dmem_ram_bytewe #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    // NOTE: the array has no reset branch on purpose; resetting storage would
    // turn it into flops instead of a block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_o <= mem_q[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the core's data-memory port (valid/ready handshake).
// Latches a request, optionally stalls for WAIT_STATES cycles, performs one
// RAM access and answers with a single-cycle mem_ready strobe. Accesses
// outside the address window answer with mem_err=1, rdata=0, no RAM write.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   mem_valid  in   request pending
//   mem_ready  out  one-cycle response strobe (registered)
//   mem_addr   in   byte address, bits [1:0] ignored
//   mem_wdata  in   store data
//   mem_wstrb  in   byte-lane write enables, 4'b0000 = read
//   mem_rdata  out  read data, meaningful only while mem_ready=1
//   mem_err    out  out-of-window flag, pulses with mem_ready (registered)
//   req_count  out  completed responses, wraps modulo 2**32
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic [31:0] req_count
);

    localparam logic [31:0] WINDOW = window_bytes(ADDR_WIDTH);
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  in_range_q;
    logic                  ready_q;
    logic                  err_q;
    logic [31:0]           count_q;

    logic                  accept;
    logic                  ram_en;
    logic [31:0]           offset;
    logic [31:0]           ram_rdata;

    // Unsigned subtract: addresses below BASE_ADDR wrap to large values and
    // fall out of the window with a single compare.
    assign offset = mem_addr - BASE_ADDR;

    // The accept edge only latches and decodes the request; WAIT always runs
    // for WAIT_STATES+1 cycles so the RAM access lands on a later edge and
    // mem_ready shows up in the cycle after edge accept+1+WAIT_STATES.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        ram_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = WS;
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    state_d = ST_IDLE;          // initiator withdrew: drop request
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    ram_en  = 1'b1;             // access happens on the edge entering RESP
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;         // mem_valid deliberately ignored here
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= WSTRB_READ;
            in_range_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q      <= offset[ADDR_WIDTH+1:2];
                wdata_q    <= mem_wdata;
                wstrb_q    <= mem_wstrb;
                in_range_q <= (offset < WINDOW);
            end
            ready_q <= ram_en;
            err_q   <= ram_en & ~in_range_q;
            if (state_q == ST_RESP) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    dmem_ram_bytewe #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (wstrb_q & {4{in_range_q}}),   // out-of-window stores never touch RAM
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign req_count = count_q;
    // RAM output is held between accesses; mask it so rdata reads 0 outside a
    // good response, after reset and on an error response.
    assign mem_rdata = (ready_q && !err_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders (WAIT_STATES=0 and WAIT_STATES=3) driven by directed
// transfers. The driver pushes the expected response into a queue; a monitor
// pops and compares whenever either DUT raises mem_ready.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid [2];
    logic        mem_ready [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic [31:0] mem_rdata [2];
    logic        mem_err   [2];
    logic [31:0] req_count [2];

    typedef struct {
        int          dut;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          ready_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nmis = 0;
    int          cyc  = 0;
    logic [31:0] cnt_exp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid[0]),
        .mem_ready (mem_ready[0]),
        .mem_addr  (mem_addr[0]),
        .mem_wdata (mem_wdata[0]),
        .mem_wstrb (mem_wstrb[0]),
        .mem_rdata (mem_rdata[0]),
        .mem_err   (mem_err[0]),
        .req_count (req_count[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid[1]),
        .mem_ready (mem_ready[1]),
        .mem_addr  (mem_addr[1]),
        .mem_wdata (mem_wdata[1]),
        .mem_wstrb (mem_wstrb[1]),
        .mem_rdata (mem_rdata[1]),
        .mem_err   (mem_err[1]),
        .req_count (req_count[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per mem_ready pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ready[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_resp: dut%0d raised mem_ready with nothing expected (t=%0t)", d, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_dut", 32'(d), 32'(mon_e.dut));
                    check("resp_err", {31'd0, mem_err[d]}, {31'd0, mon_e.err});
                    if (mon_e.chk_rd) check("resp_rdata", mem_rdata[d], mon_e.rdata);
                    check("resp_latency", 32'(cyc), 32'(mon_e.ready_cyc));
                end
            end
        end
    end

    // One full transfer on DUT d. Inputs are scrambled while the request is
    // in flight; the DUT must use the values latched at accept.
    task automatic xfer(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic chk_rd,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   seen;
        @(negedge clk);
        mem_valid[d] = 1'b1;
        mem_addr[d]  = addr;
        mem_wdata[d] = wdata;
        mem_wstrb[d] = wstrb;
        e.dut       = d;
        e.chk_rd    = chk_rd;
        e.rdata     = exp_rd;
        e.err       = exp_err;
        e.ready_cyc = cyc + 2 + ((d == 0) ? 0 : 3);
        exp_q.push_back(e);
        @(negedge clk);
        mem_addr[d]  = addr ^ 32'h0000_0004;
        mem_wdata[d] = ~wdata;
        mem_wstrb[d] = ~wstrb;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (mem_ready[d] === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            nvec++;
            nmis++;
            $display("FAIL ready_timeout: dut%0d addr 0x%08h got no mem_ready, required one within 40 cycles", d, addr);
        end
        mem_valid[d] = 1'b0;
        mem_wstrb[d] = 4'b0000;
        @(negedge clk);
        check("ready_one_cycle", {31'd0, mem_ready[d]}, 32'd0);
        if (seen) cnt_exp[d] = cnt_exp[d] + 32'd1;
        check("req_count", req_count[d], cnt_exp[d]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int d = 0; d < 2; d++) begin
            mem_valid[d] = 1'b0;
            mem_addr[d]  = '0;
            mem_wdata[d] = '0;
            mem_wstrb[d] = 4'b0000;
            cnt_exp[d]   = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", {31'd0, mem_ready[d]}, 32'd0);
            check("rst_err",   {31'd0, mem_err[d]},   32'd0);
            check("rst_rdata", mem_rdata[d], 32'd0);
            check("rst_count", req_count[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // WAIT_STATES=0: full word, byte lanes, window edges.
        xfer(0, 32'h0001_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,         1'b0);
        xfer(0, 32'h0001_0004, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 32'h0001_0004, 32'h0000_00AA, 4'b0001, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 32'h0001_0004, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEAA, 1'b0);
        xfer(0, 32'h0001_0006, 32'h5566_0000, 4'b1100, 1'b1, 32'hDEAD_BEAA, 1'b0);
        xfer(0, 32'h0001_0004, 32'h0,         4'b0000, 1'b1, 32'h5566_BEAA, 1'b0);
        xfer(0, 32'h0001_0000, 32'h1111_1111, 4'b1111, 1'b0, 32'h0,         1'b0);
        xfer(0, 32'h0001_0FFC, 32'h1234_5678, 4'b1111, 1'b0, 32'h0,         1'b0);
        xfer(0, 32'h0001_0FFC, 32'h0,         4'b0000, 1'b1, 32'h1234_5678, 1'b0);
        xfer(0, 32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1);
        xfer(0, 32'h0001_1000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,         1'b1);
        xfer(0, 32'h0001_0000, 32'h0,         4'b0000, 1'b1, 32'h1111_1111, 1'b0);

        // WAIT_STATES=3: latency and abort.
        xfer(1, 32'h0001_0008, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,         1'b0);
        xfer(1, 32'h0001_0008, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0);

        @(negedge clk);
        mem_valid[1] = 1'b1;
        mem_addr[1]  = 32'h0001_0008;
        mem_wdata[1] = 32'h0BAD_0BAD;
        mem_wstrb[1] = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        mem_valid[1] = 1'b0;
        mem_wstrb[1] = 4'b0000;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ready[1] === 1'b1) got = 1'b1;
        end
        check("abort_no_ready", {31'd0, got}, 32'd0);
        check("abort_count", req_count[1], cnt_exp[1]);
        xfer(1, 32'h0001_0008, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0);

        // Reset while a read sits in WAIT.
        @(negedge clk);
        mem_valid[1] = 1'b1;
        mem_addr[1]  = 32'h0001_0008;
        mem_wstrb[1] = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count",  req_count[1], 32'd0);
        check("async_rst_count0", req_count[0], 32'd0);
        check("async_rst_ready",  {31'd0, mem_ready[1]}, 32'd0);
        check("async_rst_rdata",  mem_rdata[1], 32'd0);
        mem_valid[1] = 1'b0;
        cnt_exp[0] = '0;
        cnt_exp[1] = '0;
        @(negedge clk);
        rst = 1'b1;
        xfer(1, 32'h0001_0008, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
